// File: rtl/if_id_pipe_reg_pkg.sv
// ---------------------------------------------------------------------------
// if_id_pkg
// Shared definitions for the IF/ID boundary register:
//   - NOP_INSTR_DEFAULT : bubble encoding shown to decode when nothing is live
//   - skid_state_t      : occupancy of the {main, skid} register pair
//   - RS/RT/RD_LSB      : bit positions of the register-specifier fields
// ---------------------------------------------------------------------------
package if_id_pkg;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0001;

    // Occupancy of the two-entry buffer: nothing, main only, main + skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    localparam int RS_LSB      = 21;
    localparam int RT_LSB      = 16;
    localparam int RD_LSB      = 11;
    localparam int REG_FIELD_W = 5;

endpackage

// File: rtl/if_id_pipe_reg_if.sv
// ---------------------------------------------------------------------------
// if_id_pipe_reg_if
// Bundles the fetch-side and decode-side handshake/bus signals of the IF/ID
// register.
//   master : fetch + decode side (drives in_*, flush, out_ready)
//   slave  : the IF/ID register itself (drives in_ready, out_*)
// Signals:
//   in_valid / in_ready / in_instr / in_pc_plus4 : fetch handshake + payload
//   flush                                        : squash all held entries
//   out_valid / out_ready / out_instr / out_pc_plus4 : decode handshake + payload
//   out_rs / out_rt / out_rd                     : register fields of out_instr
// ---------------------------------------------------------------------------
interface if_id_pipe_reg_if
    import if_id_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [XLEN-1:0]        in_instr;
    logic [PC_W-1:0]        in_pc_plus4;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [XLEN-1:0]        out_instr;
    logic [PC_W-1:0]        out_pc_plus4;
    logic [REG_FIELD_W-1:0] out_rs;
    logic [REG_FIELD_W-1:0] out_rt;
    logic [REG_FIELD_W-1:0] out_rd;

    modport master (
        output in_valid, in_instr, in_pc_plus4, flush, out_ready,
        input  in_ready, out_valid, out_instr, out_pc_plus4, out_rs, out_rt, out_rd
    );

    modport slave (
        input  in_valid, in_instr, in_pc_plus4, flush, out_ready,
        output in_ready, out_valid, out_instr, out_pc_plus4, out_rs, out_rt, out_rd
    );

endinterface

// File: rtl/if_id_pipe_reg_skid2.sv
// ---------------------------------------------------------------------------
// pipe_skid2
// Generic two-entry skid buffer with synchronous flush.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : upstream handshake (in_ready is registered)
//   in_data  [W]        : upstream payload
//   flush               : drop every held entry, wins over accept/consume
//   out_valid/out_ready : downstream handshake
//   out_data [W]        : head entry (holds its last value when empty)
// in_ready depends only on registered state, so a downstream stall never
// forms a combinational path back to the producer; the skid entry absorbs
// the one transfer that is already in flight when the stall is seen.
// ---------------------------------------------------------------------------
module pipe_skid2
    import if_id_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_t  state;
    skid_state_t  next_state;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         accept;
    logic         consume;
    logic         load_main_in;
    logic         load_main_skid;
    logic         load_skid_in;

    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;
    assign out_data  = main_q;

    // State register; in_ready is registered from the next state so it is
    // already low on the first cycle spent in FULL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= next_state;
            in_ready <= (next_state != FULL);
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) next_state = HALF;
                HALF: begin
                    if (accept && !consume)      next_state = FULL;
                    else if (!accept && consume) next_state = EMPTY;
                end
                FULL:  if (consume) next_state = HALF;
                default: next_state = EMPTY;
            endcase
        end
    end

    // Datapath load enables. A flush suppresses every load so the head
    // register keeps its last payload (decode ignores it while invalid).
    always_comb begin
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (!flush) begin
            case (state)
                EMPTY: load_main_in = accept;
                HALF: begin
                    load_main_in = accept & consume;
                    load_skid_in = accept & ~consume;
                end
                FULL:  load_main_skid = consume;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)        main_q <= in_data;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid_in)        skid_q <= in_data;
        end
    end

endmodule

// File: rtl/if_id_pipe_reg.sv
// ---------------------------------------------------------------------------
// if_id_pipe_reg
// IF/ID boundary register of the 5-stage pipeline. Carries the fetched
// instruction and its PC+4 into decode through a two-entry skid buffer and
// exposes the rs/rt/rd register-specifier fields.
// Ports:
//   clk    : clock, all state updates on posedge
//   rst_n  : asynchronous active-low reset
//   bus    : if_id_pipe_reg_if.slave (fetch handshake, flush, decode handshake,
//            out_instr / out_pc_plus4 / out_rs / out_rt / out_rd)
// When no entry is live, out_instr shows NOP_INSTR so decode sees a bubble;
// out_pc_plus4 keeps its last value and must be ignored by decode.
// ---------------------------------------------------------------------------
module if_id_pipe_reg
    import if_id_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              PC_W      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_INSTR_DEFAULT)
) (
    input logic              clk,
    input logic              rst_n,
    if_id_pipe_reg_if.slave  bus
);

    localparam int W = XLEN + PC_W;

    logic [W-1:0]    head;
    logic            head_valid;
    logic [XLEN-1:0] instr_view;

    // Instruction and PC+4 travel as one word so they can never separate.
    pipe_skid2 #(
        .W (W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   ({bus.in_instr, bus.in_pc_plus4}),
        .flush     (bus.flush),
        .out_valid (head_valid),
        .out_ready (bus.out_ready),
        .out_data  (head)
    );

    assign instr_view = head_valid ? head[W-1 -: XLEN] : NOP_INSTR;

    assign bus.out_valid    = head_valid;
    assign bus.out_instr    = instr_view;
    assign bus.out_pc_plus4 = head[PC_W-1:0];

    // Fields are sliced after NOP masking so a bubble decodes as a bubble.
    assign bus.out_rs = instr_view[RS_LSB +: REG_FIELD_W];
    assign bus.out_rt = instr_view[RT_LSB +: REG_FIELD_W];
    assign bus.out_rd = instr_view[RD_LSB +: REG_FIELD_W];

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_if_id_pipe_reg
// Self-checking bench for if_id_pipe_reg. The reference model is a FIFO
// queue of {instr, pc_plus4} with capacity two, plus the last head PC.
// ---------------------------------------------------------------------------
module tb_if_id_pipe_reg;

    localparam int XLEN = 32;
    localparam int PC_W = 32;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    if_id_pipe_reg_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();

    if_id_pipe_reg #(.XLEN(XLEN), .PC_W(PC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [63:0] mq[$];
    logic [31:0] last_pc;
    int          vectors;
    int          miscompares;

    // {out_valid, in_ready, out_instr, out_pc_plus4, rs, rt, rd}
    function automatic logic [80:0] expected();
        logic        v;
        logic        rdy;
        logic [31:0] ins;
        v   = (mq.size() > 0);
        rdy = (mq.size() < 2);
        ins = v ? mq[0][63:32] : 32'h0000_0001;
        return {v, rdy, ins, last_pc,
                5'((ins >> 21) % 32), 5'((ins >> 16) % 32), 5'((ins >> 11) % 32)};
    endfunction

    function automatic logic [80:0] observed();
        return {bus.out_valid, bus.in_ready, bus.out_instr, bus.out_pc_plus4,
                bus.out_rs, bus.out_rt, bus.out_rd};
    endfunction

    function automatic void model_reset();
        mq.delete();
        last_pc = '0;
    endfunction

    // Drive one cycle of inputs, advance the clock, update the model.
    task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                        input logic fl, input logic ordy);
        logic acc;
        logic con;
        bus.in_valid    = iv;
        bus.in_instr    = ins;
        bus.in_pc_plus4 = pc;
        bus.flush       = fl;
        bus.out_ready   = ordy;
        acc = iv && (mq.size() < 2);
        con = ordy && (mq.size() > 0);
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (con) void'(mq.pop_front());
            if (acc) mq.push_back({ins, pc});
        end
        if (mq.size() > 0) last_pc = mq[0][31:0];
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            bus.in_valid    = 1'($urandom);
            bus.in_instr    = $urandom;
            bus.in_pc_plus4 = $urandom;
            bus.flush       = 1'($urandom);
            bus.out_ready   = 1'($urandom);
            @(posedge clk);
            #1;
            if ({bus.out_valid, bus.out_instr, bus.out_pc_plus4, bus.in_ready} !==
                {1'b0, 32'h0000_0001, 32'h0, 1'b1}) begin
                miscompares++;
                $display("FAIL reset[%0d] got v=%b instr=%h pc=%h rdy=%b, want v=0 instr=00000001 pc=0 rdy=1",
                         i, bus.out_valid, bus.out_instr, bus.out_pc_plus4, bus.in_ready);
            end
            vectors++;
        end
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        if (observed() !== expected()) begin
            miscompares++;
            $display("FAIL reset_release got %h want %h", observed(), expected());
        end
        vectors++;
    endtask

    task automatic test_stream();
        logic [31:0] ins[3];
        logic [31:0] pcs[3];
        pcs = '{32'd4, 32'd8, 32'd12};
        for (int i = 0; i < 3; i++) ins[i] = $urandom;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, ins[i], pcs[i], 1'b0, 1'b1);
            if ({bus.out_valid, bus.out_instr, bus.out_pc_plus4} !== {1'b1, ins[i], pcs[i]}) begin
                miscompares++;
                $display("FAIL stream[%0d] got v=%b %h/%0d want v=1 %h/%0d",
                         i, bus.out_valid, bus.out_instr, bus.out_pc_plus4, ins[i], pcs[i]);
            end
            vectors++;
        end
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        if (observed() !== expected() || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_drain got %h want %h", observed(), expected());
        end
        vectors++;
    endtask

    task automatic test_stall();
        logic [31:0] a;
        logic [31:0] b;
        a = $urandom;
        b = $urandom;
        step(1'b1, a, 32'h100, 1'b0, 1'b0);
        step(1'b1, b, 32'h104, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            if ({bus.in_ready, bus.out_valid, bus.out_instr, bus.out_pc_plus4} !==
                {1'b0, 1'b1, a, 32'h100}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d] got rdy=%b v=%b %h/%h want rdy=0 v=1 %h/00000100",
                         i, bus.in_ready, bus.out_valid, bus.out_instr, bus.out_pc_plus4, a);
            end
            vectors++;
            step(1'b1, $urandom, 32'h200, 1'b0, 1'b0);
        end
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        if ({bus.out_valid, bus.out_instr, bus.out_pc_plus4, bus.in_ready} !== {1'b1, b, 32'h104, 1'b1}) begin
            miscompares++;
            $display("FAIL stall_release got v=%b %h/%h rdy=%b want v=1 %h/00000104 rdy=1",
                     bus.out_valid, bus.out_instr, bus.out_pc_plus4, bus.in_ready, b);
        end
        vectors++;
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        if (observed() !== expected()) begin
            miscompares++;
            $display("FAIL stall_drain got %h want %h", observed(), expected());
        end
        vectors++;
    endtask

    task automatic test_flush();
        logic [31:0] d;
        d = 32'hDDDD_0D0D;
        step(1'b1, $urandom, 32'h300, 1'b0, 1'b0);
        step(1'b1, $urandom, 32'h304, 1'b0, 1'b0);
        step(1'b1, d, 32'h308, 1'b1, 1'b1);
        if ({bus.out_valid, bus.out_instr, bus.in_ready} !== {1'b0, 32'h0000_0001, 1'b1}) begin
            miscompares++;
            $display("FAIL flush got v=%b instr=%h rdy=%b want v=0 instr=00000001 rdy=1",
                     bus.out_valid, bus.out_instr, bus.in_ready);
        end
        vectors++;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
            if (bus.out_valid !== 1'b0 || bus.out_instr === d || observed() !== expected()) begin
                miscompares++;
                $display("FAIL flush_after[%0d] got %h want %h", i, observed(), expected());
            end
            vectors++;
        end
    endtask

    task automatic test_fields();
        step(1'b1, 32'h014B_4820, 32'h400, 1'b0, 1'b0);
        if ({bus.out_rs, bus.out_rt, bus.out_rd} !== {5'd10, 5'd11, 5'd9}) begin
            miscompares++;
            $display("FAIL fields got rs=%0d rt=%0d rd=%0d want rs=10 rt=11 rd=9",
                     bus.out_rs, bus.out_rt, bus.out_rd);
        end
        vectors++;
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        if ({bus.out_valid, bus.out_rs, bus.out_rt, bus.out_rd} !== {1'b0, 5'd0, 5'd0, 5'd0}) begin
            miscompares++;
            $display("FAIL fields_bubble got v=%b rs=%0d rt=%0d rd=%0d want v=0 rs=rt=rd=0",
                     bus.out_valid, bus.out_rs, bus.out_rt, bus.out_rd);
        end
        vectors++;
    endtask

    task automatic test_async_reset();
        logic [31:0] e;
        e = $urandom;
        step(1'b1, $urandom, 32'h500, 1'b0, 1'b0);
        step(1'b1, $urandom, 32'h504, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        if ({bus.out_valid, bus.out_instr, bus.out_pc_plus4, bus.in_ready} !==
            {1'b0, 32'h0000_0001, 32'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL async_reset got v=%b instr=%h pc=%h rdy=%b want v=0 instr=00000001 pc=0 rdy=1",
                     bus.out_valid, bus.out_instr, bus.out_pc_plus4, bus.in_ready);
        end
        vectors++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, e, 32'h600, 1'b0, 1'b1);
        if ({bus.out_valid, bus.out_instr, bus.out_pc_plus4} !== {1'b1, e, 32'h600}) begin
            miscompares++;
            $display("FAIL async_reset_accept got v=%b %h/%h want v=1 %h/00000600",
                     bus.out_valid, bus.out_instr, bus.out_pc_plus4, e);
        end
        vectors++;
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, $urandom, $urandom, ($urandom % 16) == 0, ($urandom % 3) != 0);
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL random[%0d] got %h want %h", i, observed(), expected());
            end
            vectors++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        bus.in_valid    = 1'b0;
        bus.in_instr    = '0;
        bus.in_pc_plus4 = '0;
        bus.flush       = 1'b0;
        bus.out_ready   = 1'b0;
        rst_n = 1'b0;
        model_reset();
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_fields();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
